// File: rtl/nkmm_prog_loader_pkg.sv
// Shared types and constants for the nkmm program loader slice.
// The instruction width comes from `INSN_WIDTH (defaults to 32 when not provided by the build).
`ifndef INSN_WIDTH
`define INSN_WIDTH 32
`endif

package nkmm_prog_loader_pkg;

  localparam int INSN_W          = `INSN_WIDTH;
  localparam int BPW             = INSN_W / 8;
  localparam int PROG_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_FIN  = 2'd2
  } ld_state_e;

endpackage

// File: rtl/nkmm_prog_loader_if.sv
// Byte-serial load channel: host drives bytes, loader reports handshake and session status.
interface nkmm_prog_loader_if #(
  parameter int ADDR_WIDTH = 10
) ();
  logic                  ld_start_i;
  logic [7:0]            ld_data_i;
  logic                  ld_valid_i;
  logic                  ld_last_i;
  logic                  ld_ready_o;
  logic                  ld_busy_o;
  logic                  ld_done_o;
  logic                  ld_err_o;
  logic [ADDR_WIDTH:0]   word_count_o;

  modport master (
    output ld_start_i, ld_data_i, ld_valid_i, ld_last_i,
    input  ld_ready_o, ld_busy_o, ld_done_o, ld_err_o, word_count_o
  );

  modport slave (
    input  ld_start_i, ld_data_i, ld_valid_i, ld_last_i,
    output ld_ready_o, ld_busy_o, ld_done_o, ld_err_o, word_count_o
  );
endinterface

// File: rtl/nkmm_prog_loader_ram.sv
// Program RAM: single write port, registered read-first read port; maps onto block RAM.
module nkmm_prog_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Non-blocking read of the same array gives old data on a same-address write.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end
endmodule

// File: rtl/nkmm_prog_loader.sv
// Program store in front of nkmm_cpu: byte-serial loader, word packer and instruction RAM.
// Optional feature macro: NKMM_PROG_CHECKSUM_EN adds checksum_o (sum of words written this session).
module nkmm_prog_loader
  import nkmm_prog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = PROG_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  nkmm_prog_loader_if.slave     ld,
  output logic                  cpu_rst_o,
  input  logic [ADDR_WIDTH-1:0] prog_addr_i,
  output logic [INSN_W-1:0]     prog_data_o
`ifdef NKMM_PROG_CHECKSUM_EN
  ,
  output logic [INSN_W-1:0]     checksum_o
`endif
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int BIW   = $clog2(BPW);

  ld_state_e                  state_q, state_d;
  logic [BIW-1:0]             byte_idx_q;
  logic [BPW-2:0][7:0]        buf_q;
  logic [BPW-1:0][7:0]        word_d;
  logic [ADDR_WIDTH-1:0]      wr_addr_q;
  logic [ADDR_WIDTH:0]        word_cnt_q;
  logic                       err_q, cpu_rst_q;
  logic                       ready, busy, done;
  logic                       accept, last_lane, commit, full, ram_we;

  assign accept    = ld.ld_valid_i & (state_q == LD_LOAD) & ~ld.ld_start_i;
  assign last_lane = (byte_idx_q == BIW'(BPW-1));
  assign commit    = accept & (last_lane | ld.ld_last_i);
  assign full      = (word_cnt_q == (ADDR_WIDTH+1)'(DEPTH));
  assign ram_we    = commit & ~full;

  // Lanes below the current index come from the buffer, the current lane from the bus, the rest pad to zero.
  for (genvar l = 0; l < BPW; l++) begin : g_lane
    if (l < BPW-1) begin : g_buf
      assign word_d[l] = (BIW'(l) == byte_idx_q) ? ld.ld_data_i :
                         (BIW'(l) <  byte_idx_q) ? buf_q[l] : 8'h00;
    end else begin : g_top
      assign word_d[l] = (BIW'(l) == byte_idx_q) ? ld.ld_data_i : 8'h00;
    end
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      LD_IDLE: if (ld.ld_start_i) state_d = LD_LOAD;
      LD_LOAD: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (ld.ld_start_i)               state_d = LD_LOAD;
        else if (commit & ld.ld_last_i)  state_d = LD_FIN;
      end
      LD_FIN: begin
        done    = 1'b1;
        state_d = ld.ld_start_i ? LD_LOAD : LD_IDLE;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LD_IDLE;
      byte_idx_q <= '0;
      buf_q      <= '0;
      wr_addr_q  <= '0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
      cpu_rst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (ld.ld_start_i) begin
        byte_idx_q <= '0;
        wr_addr_q  <= '0;
        word_cnt_q <= '0;
        err_q      <= 1'b0;
        cpu_rst_q  <= 1'b1;
      end else begin
        if (accept) begin
          buf_q      <= word_d[BPW-2:0];
          byte_idx_q <= commit ? '0 : byte_idx_q + 1'b1;
        end
        if (commit) begin
          if (!full) begin
            wr_addr_q  <= wr_addr_q + 1'b1;
            word_cnt_q <= word_cnt_q + 1'b1;
          end
          if (full | (ld.ld_last_i & ~last_lane)) err_q <= 1'b1;
        end
        // The CPU is released after any completed session, error or not.
        if (state_q == LD_FIN) cpu_rst_q <= 1'b0;
      end
    end
  end

`ifdef NKMM_PROG_CHECKSUM_EN
  logic [INSN_W-1:0] csum_q;
  always_ff @(posedge clk) begin
    if (rst || ld.ld_start_i) csum_q <= '0;
    else if (ram_we)          csum_q <= csum_q + word_d;
  end
  assign checksum_o = csum_q;
`endif

  assign ld.ld_ready_o   = ready;
  assign ld.ld_busy_o    = busy;
  assign ld.ld_done_o    = done;
  assign ld.ld_err_o     = err_q;
  assign ld.word_count_o = word_cnt_q;
  assign cpu_rst_o       = cpu_rst_q;

  nkmm_prog_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (INSN_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (wr_addr_q),
    .wdata (word_d),
    .raddr (prog_addr_i),
    .rdata (prog_data_o)
  );
endmodule
